// File: rtl/multicycle_main_fsm_pkg.sv
// rtl/multicycle_main_fsm_pkg.sv - shared opcodes, state encoding and mux selects for the multicycle controller
package multicycle_main_fsm_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } mainStateT;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_imm_src_decode.sv
// rtl/multicycle_main_fsm_imm_src_decode.sv - combinational opcode to immediate-format select
module multicycle_main_fsm_imm_src_decode
  import multicycle_main_fsm_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output logic [1:0]      immSrc
);

  // Loads, ALU-immediate and R-type all fall back to the I format.
  always_comb begin
    immSrc = IMM_I;
    if (op == OP_W'(OP_SW))       immSrc = IMM_S;
    else if (op == OP_W'(OP_BEQ)) immSrc = IMM_B;
    else if (op == OP_W'(OP_JAL)) immSrc = IMM_J;
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle RV32I main controller state machine
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int HAS_JAL  = 1,
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               adrSrc,
  output logic               memWrite,
  output logic               irWrite,
  output logic [1:0]         resultSrc,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic               regWrite,
  output logic [1:0]         immSrc,
  output logic               illegalOp,
  output logic [STATE_W-1:0] stateOut
);

  localparam logic [OP_W-1:0] opLw  = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] opSw  = OP_W'(OP_SW);
  localparam logic [OP_W-1:0] opR   = OP_W'(OP_R);
  localparam logic [OP_W-1:0] opI   = OP_W'(OP_I);
  localparam logic [OP_W-1:0] opBeq = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] opJal = OP_W'(OP_JAL);

  mainStateT state, nextState;
  logic      rdy;
  logic      pcUpdate, branch, memWriteRaw, irWriteRaw, regWriteRaw;

  assign rdy = (MEM_WAIT != 0) ? memReady : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegalOp <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState == TRAP) illegalOp <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (rdy) nextState = DECODE;
      DECODE: begin
        if (op == opLw || op == opSw)         nextState = MEMADR;
        else if (op == opR)                   nextState = EXECR;
        else if (op == opI)                   nextState = EXECI;
        else if (op == opBeq)                 nextState = BEQ;
        else if (HAS_JAL != 0 && op == opJal) nextState = JAL;
        else                                  nextState = TRAP;
      end
      MEMADR:   nextState = (op == opSw) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (rdy) nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: if (rdy) nextState = FETCH;
      EXECR:    nextState = ALUWB;
      EXECI:    nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      JAL:      nextState = ALUWB;
      TRAP:     nextState = TRAP;
      default:  nextState = TRAP;
    endcase
  end

  always_comb begin
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = RES_ALUOUT;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    case (state)
      FETCH: begin
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALURESULT;
        irWriteRaw = rdy;
        pcUpdate   = rdy;
      end
      DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      MEMREAD:  adrSrc = 1'b1;
      MEMWB: begin
        resultSrc   = RES_DATA;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        adrSrc      = 1'b1;
        memWriteRaw = rdy;
      end
      EXECR: begin
        aluSrcA = SRCA_RS1;
        aluOp   = ALUOP_FUNCT;
      end
      EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      ALUWB:    regWriteRaw = 1'b1;
      BEQ: begin
        aluSrcA = SRCA_RS1;
        aluOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        aluSrcA  = SRCA_OLDPC;
        aluSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
      end
      default: ;
    endcase
  end

  // FETCH is the reset state and may see memReady high, so gate enables on rst_n too.
  assign pcWrite  = rst_n & (pcUpdate | (branch & zero));
  assign memWrite = rst_n & memWriteRaw;
  assign irWrite  = rst_n & irWriteRaw;
  assign regWrite = rst_n & regWriteRaw;
  assign stateOut = STATE_W'(state);

  multicycle_main_fsm_imm_src_decode #(.OP_W(OP_W)) uImmSrc (
    .op     (op),
    .immSrc (immSrc)
  );

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Parametrised multicycle successor to the single-cycle main decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives the shared-ALU, single-memory multicycle datapath, with an optional memory-ready handshake and an illegal-opcode trap.
- Sits in the controller beside the existing ALU decoder, which consumes aluOp.

Parameters:
- OP_W, 7: opcode width.
- HAS_JAL, 1: 1 enables the jal (1101111) path; 0 treats jal as illegal.
- MEM_WAIT, 1: 1 means memory states wait for memReady; 0 ignores memReady (treated as 1).
- STATE_W, 4: state encoding width, exported on stateOut.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  OP_W  opcode from the instruction register
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes the current access this cycle
- pcWrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- memWrite  out  1  data memory write strobe
- irWrite  out  1  instruction register / oldPC enable
- resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  out  2  00=PC, 01=oldPC, 10=rs1
- aluSrcB  out  2  00=rs2, 01=imm, 10=const 4
- aluOp  out  2  00=add, 01=sub/branch, 10=funct-decoded
- regWrite  out  1  register file write enable
- immSrc  out  2  00=I, 01=S, 10=B, 11=J
- illegalOp  out  1  sticky trap flag
- stateOut  out  STATE_W  current state, for debug

Behaviour:
- Reset: clk and rst_n are decided as above (one clock; asynchronous, active-low reset). While rst_n=0, state=FETCH, illegalOp=0, and every enable (pcWrite, memWrite, irWrite, regWrite) is forced to 0.
- Outputs are Moore, decoded from the registered state, except:
  - immSrc is combinational from op, using the same mapping as the single-cycle decoder plus jal→11.
  - pcWrite includes (branch & zero).
  - The handshake gates use memReady.
- Ready signal: rdy = MEM_WAIT ? memReady : 1.
- State encodings 0-11, in order: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH:
  - Outputs: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite=pcWrite=rdy.
  - Stays in FETCH while rdy=0; goes to DECODE when rdy=1.
- DECODE:
  - Outputs: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target computed into ALUOut).
  - Next state by op: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BEQ; 1101111→JAL if HAS_JAL; anything else→TRAP.
- MEMADR:
  - Outputs: aluSrcA=10, aluSrcB=01, aluOp=00.
  - lw→MEMREAD; sw→MEMWRITE.
- MEMREAD: resultSrc=00, adrSrc=1. Waits for rdy, then →MEMWB.
- MEMWB: resultSrc=01, regWrite=1; →FETCH.
- MEMWRITE: resultSrc=00, adrSrc=1, memWrite=rdy. Waits for rdy, then →FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10; →ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10; →ALUWB.
- ALUWB: resultSrc=00, regWrite=1; →FETCH.
- BEQ:
  - Outputs: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, so pcWrite=zero.
  - →FETCH.
- JAL:
  - Outputs: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1.
  - →ALUWB, which writes PC+4 to rd.
- TRAP:
  - Sets illegalOp=1 on entry and holds it.
  - All enables stay 0. TRAP is absorbing until rst_n is asserted.
- Default outputs in each state are 0 unless listed above.
- Latency per instruction type:
  - lw: 5 cycles plus fetch and read wait cycles.
  - sw: 4 cycles plus fetch and write wait cycles.
  - R-type and I-type: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
- memWrite and irWrite assert for exactly one cycle per access, regardless of how many wait cycles precede it.
- Reset mid-instruction aborts immediately. No partial write may occur after rst_n falls.
- op is sampled only in DECODE and MEMADR; it must be stable from the IR after FETCH.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - State enum typedef.
  - Mux-select constants for resultSrc, aluSrcA, aluSrcB, aluOp and immSrc.
- Natural sub-module: imm_src_decode, the combinational op→immSrc decoder.

Test Plan:
- lw (op=0000011), memReady=1 always → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regWrite=1 only in cycle 5; resultSrc=01 in MEMWB.
- sw with memReady low for 3 cycles in MEMWRITE → stays in MEMWRITE 4 cycles; memWrite high only in the 4th; then FETCH.
- beq with zero=1 → pcWrite=1 in BEQ. Repeat with zero=0 → pcWrite=0; total 3 cycles.
- Combined jal case: HAS_JAL=1, op=1101111 → DECODE→JAL (pcWrite=1) →ALUWB (regWrite=1). Same op with HAS_JAL=0 → TRAP, illegalOp=1 held; no enables for 10 cycles.
- Illegal op=0000000 → TRAP, illegalOp=1; rst_n pulse → FETCH, illegalOp=0.
- rst_n asserted low during MEMWRITE wait → state=FETCH asynchronously, memWrite=0 the same cycle; MEM_WAIT=0 variant fetches in 1 cycle while memReady held at 0.
